// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: operand/request and result bundle for the bit-serial add/sub unit
interface serial_add_sub_if #(parameter int WIDTH = 4);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   result;
   modport master (output start, a, b, sub, input busy, done, result);
   modport slave (input start, a, b, sub, output busy, done, result);
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one result bit per clock, LSB first
module serial_add_sub #(parameter int WIDTH = 4) (
   input logic            clk,
   input logic            rst_n,
   serial_add_sub_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, nxt;
   logic [WIDTH:0] ra, rb, acc, res;
   logic [CW-1:0] cnt;
   logic op, cy, bb, s;
   // subtraction is A + ~B + 1: invert B per bit, carry starts at sub
   assign bb = rb[0] ^ op;
   assign s = ra[0] ^ bb ^ cy;
   always_comb begin
      nxt = state == RUN ? (cnt == LAST ? DONE : RUN) : (bus.start ? RUN : IDLE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra <= '0;
         rb <= '0;
         acc <= '0;
         res <= '0;
         cnt <= '0;
         op <= 1'b0;
         cy <= 1'b0;
      end else if (state != RUN) begin
         if (bus.start) begin
            ra <= {1'b0, bus.a};
            rb <= {1'b0, bus.b};
            op <= bus.sub;
            cy <= bus.sub;
            cnt <= '0;
            acc <= '0;
         end
      end else begin
         ra <= {1'b0, ra[WIDTH:1]};
         rb <= {1'b0, rb[WIDTH:1]};
         cy <= (ra[0] & bb) | (ra[0] & cy) | (bb & cy);
         acc <= {s, acc[WIDTH:1]};
         cnt <= cnt + 1'b1;
         if (cnt == LAST) res <= {s, acc[WIDTH:1]};
      end
   end
   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
   assign bus.result = res;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed self-checking bench for serial_add_sub
module tb_serial_add_sub;
   logic clk, rst_n;
   int total, bad;
   serial_add_sub_if #(.WIDTH(4)) bus();
   serial_add_sub #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // issues one request at a negedge and returns at the negedge where done is seen
   task automatic do_op(input logic [3:0] x, input logic [3:0] y, input logic s,
                        output logic [4:0] r, output int nb, output bit ok);
      bus.start = 1'b1; bus.a = x; bus.b = y; bus.sub = s;
      @(negedge clk);
      bus.start = 1'b0;
      nb = 0; ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.done) ok = 1'b1;
         else begin
            if (bus.busy) nb++;
            @(negedge clk);
         end
      end
      r = bus.result;
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      total++; if (bus.result !== 5'd0) begin bad++; $display("FAIL reset_result got=%0d want=0", bus.result); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_add;
      logic [4:0] r; int nb; bit ok;
      do_op(4'd5, 4'd6, 1'b0, r, nb, ok);
      total++; if (!ok) begin bad++; $display("FAIL add_timeout got=no_done want=done"); end
      total++; if (nb !== 5) begin bad++; $display("FAIL add_busy_cycles got=%0d want=5", nb); end
      total++; if (r !== 5'd11) begin bad++; $display("FAIL add_result got=%0d want=11", r); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL add_busy_with_done got=%b want=0", bus.busy); end
      @(negedge clk);
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b want=0", bus.done); end
      repeat (3) @(negedge clk);
      total++; if (bus.result !== 5'd11) begin bad++; $display("FAIL add_hold got=%0d want=11", bus.result); end
   endtask
   task automatic test_carry;
      logic [4:0] r; int nb; bit ok;
      do_op(4'd15, 4'd10, 1'b0, r, nb, ok);
      total++; if (!ok || r !== 5'd25) begin bad++; $display("FAIL carry_15_10 got=%0d ok=%0d want=25", r, ok); end
      @(negedge clk);
      do_op(4'd1, 4'd10, 1'b0, r, nb, ok);
      total++; if (!ok || r !== 5'd11) begin bad++; $display("FAIL carry_1_10 got=%0d ok=%0d want=11", r, ok); end
      @(negedge clk);
   endtask
   task automatic test_sub;
      logic [4:0] r; int nb; bit ok;
      do_op(4'd10, 4'd3, 1'b1, r, nb, ok);
      total++; if (!ok || r !== 5'd7) begin bad++; $display("FAIL sub_10_3 got=%0d ok=%0d want=7", r, ok); end
      @(negedge clk);
      do_op(4'd3, 4'd10, 1'b1, r, nb, ok);
      total++; if (!ok || r !== 5'd25) begin bad++; $display("FAIL sub_3_10 got=%0d ok=%0d want=25", r, ok); end
      @(negedge clk);
      do_op(4'd15, 4'd15, 1'b1, r, nb, ok);
      total++; if (!ok || r !== 5'd0) begin bad++; $display("FAIL sub_15_15 got=%0d ok=%0d want=0", r, ok); end
      @(negedge clk);
   endtask
   task automatic test_back_to_back;
      int last, n, both;
      last = -1; n = 0; both = 0;
      bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd10; bus.sub = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.done && bus.busy) both++;
         if (bus.done) begin
            total++; if (bus.result !== 5'd5) begin bad++; $display("FAIL b2b_result got=%0d want=5", bus.result); end
            if (last >= 0) begin
               total++; if (c - last !== 6) begin bad++; $display("FAIL b2b_period got=%0d want=6", c - last); end
            end
            last = c; n++;
         end
      end
      bus.start = 1'b0;
      total++; if (n < 4) begin bad++; $display("FAIL b2b_count got=%0d want>=4", n); end
      total++; if (both !== 0) begin bad++; $display("FAIL b2b_done_and_busy got=%0d want=0", both); end
      for (int i = 0; i < 10 && (bus.busy || bus.done); i++) @(negedge clk);
      total++; if (bus.busy || bus.done) begin bad++; $display("FAIL b2b_idle got=%b%b want=00", bus.busy, bus.done); end
   endtask
   task automatic test_ignore;
      bit ok;
      ok = 1'b0;
      bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd6; bus.sub = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.a = 4'd0; bus.sub = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.done) ok = 1'b1;
         else @(negedge clk);
      end
      total++; if (!ok || bus.result !== 5'd11) begin bad++; $display("FAIL ignore_result got=%0d ok=%0d want=11", bus.result, ok); end
      @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_not_queued got=%b want=0", bus.busy); end
      @(negedge clk);
   endtask
   task automatic test_reset_mid;
      logic [4:0] r; int nb, dn; bit ok;
      dn = 0;
      bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd15; bus.sub = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", bus.done); end
      total++; if (bus.result !== 5'd0) begin bad++; $display("FAIL midrst_result got=%0d want=0", bus.result); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.done || bus.busy) dn++;
      end
      total++; if (dn !== 0) begin bad++; $display("FAIL midrst_aborted got=%0d want=0", dn); end
      do_op(4'd2, 4'd3, 1'b0, r, nb, ok);
      total++; if (!ok || r !== 5'd5) begin bad++; $display("FAIL midrst_fresh got=%0d ok=%0d want=5", r, ok); end
      @(negedge clk);
   endtask
   task automatic test_sweep;
      logic [4:0] r, e; logic [3:0] x; logic s; int nb; bit ok;
      for (int i = 0; i < 15; i++) begin
         x = 4'(i);
         s = ^x;
         e = s ? 5'({1'b0, x} - 5'd3) : {1'b0, x} + 5'd3;
         do_op(x, 4'd3, s, r, nb, ok);
         total++; if (!ok || r !== e) begin bad++; $display("FAIL sweep a=%0d sub=%0d got=%0d ok=%0d want=%0d", x, s, r, ok, e); end
         @(negedge clk);
      end
   endtask
   initial begin
      total = 0; bad = 0;
      test_reset;
      test_add;
      test_carry;
      test_sub;
      test_back_to_back;
      test_ignore;
      test_reset_mid;
      test_sweep;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor: the sequential, handshaked operand consumer for the 4-bit combinational add/sub path.
- Accepts one operand pair and an operation select on a start strobe.
- Computes one result bit per clock, LSB first, over WIDTH+1 cycles.
- Presents a registered (WIDTH+1)-bit result with a one-cycle done pulse.
- Used where area matters more than latency; the result is bit-identical to the combinational add/sub unit.

Parameters:
WIDTH, 4, operand width in bits; the result is WIDTH+1 bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request strobe; sampled only when the block is idle or in the DONE cycle.
a  input  WIDTH  operand A, unsigned; sampled with start.
b  input  WIDTH  operand B, unsigned; sampled with start.
sub  input  1  0 selects A+B, 1 selects A-B; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; result is valid from this cycle onward.
result  output  WIDTH+1  registered result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0.
  - All internal registers (operand shifters, carry, bit counter, accumulator) cleared.
  - Reset asserted mid-operation aborts the operation: no done, result=0.
- Arithmetic:
  - result = ({1'b0,a} + ({1'b0,b} ^ {(WIDTH+1){sub}}) + sub) mod 2^(WIDTH+1).
  - Add: result[WIDTH] is the carry-out.
  - Subtract: the result is the (WIDTH+1)-bit two's-complement difference, so result[WIDTH]=1 means A<B.
- States IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On a rising edge with start=1: latch a and b zero-extended to WIDTH+1 bits, latch sub, set carry=sub, set bit counter=0, go to RUN.
- RUN:
  - busy=1.
  - Each edge: sum bit = a_lsb ^ (b_lsb^sub) ^ carry; carry = majority(a_lsb, b_lsb^sub, carry).
  - The sum bit shifts into the accumulator MSB; the operand registers shift right (the zero-extended MSB supplies the top bit); counter increments.
  - On the edge that processes bit index WIDTH (the (WIDTH+1)th RUN edge): load result from the final accumulator value, set done=1, busy=0, go to DONE.
  - The final carry-out is discarded (mod 2^(WIDTH+1)).
- DONE:
  - Lasts exactly one cycle; done=1.
  - Next edge: done=0.
  - If start=1 on that edge, accept the new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- Latency: with start sampled at edge 0, done is high for the cycle following edge WIDTH+1 (edge 5 for WIDTH=4). Throughput is one operation per WIDTH+2 cycles.
- result holds its value through IDLE and through the whole of the next RUN. It changes only at the done edge or on reset.
- start while busy=1 (RUN) is ignored and not queued. Changes on a, b or sub during RUN have no effect.
- done and busy are never high in the same cycle.

Test Plan:
- Add, no carry: a=5, b=6, sub=0, pulse start -> busy=1 for 5 cycles; done pulses once after edge 5; result=5'b01011 (11), held afterwards.
- Add with carry-out: a=15, b=10, sub=0 -> result=5'b11001 (25); a=1, b=10 -> result=5'b01011 (11).
- Subtract: a=10, b=3, sub=1 -> result=5'b00111 (7); a=3, b=10 -> result=5'b11001 (-7); a=15, b=15 -> result=5'b00000.
- Handshake:
  - Hold start=1 continuously with a=15, b=10, sub=1 -> back-to-back operations, done every 6 cycles, result=5'b00101 (5).
  - Change a to 0 and pulse start mid-RUN -> ignored; the result still reflects the original operands.
- Reset mid-op: start a=15, b=15, sub=0; assert rst_n=0 asynchronously after edge 2 -> busy, done and result go to 0 immediately, with no done pulse. After release, a fresh start with a=2, b=3, sub=0 -> result=5'b00101.
- Sweep: b=3; a=0..14 with sub=^a, one operation each -> every result equals the formula above; the bench compares against a combinational reference model.
